// File: rtl/seq_unpack_pkg.sv
// Shared definitions for the sequence unpacker: FSM states, terminator code, symbols-per-word.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package seq_unpack_pkg;

  // Word-level control: wait for a word, capture it, then stream its symbols.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FETCH = 2'd1,
    EMIT  = 2'd2
  } state_t;

  // The terminator is the all-ones symbol; users take the low symbol-width bits.
  localparam logic [31:0] TERM_ONES = '1;

  // Whole symbols that fit in one packed word; leftover upper bits are ignored.
  function automatic int nsym_of(input int ww, input int tw);
    return ww / tw;
  endfunction

endpackage

// File: rtl/seq_unpack_buf.sv
// Word register that loads a packed word and shifts out one symbol at a time.
// Latency: load/shift take effect on the next rising edge; sym is combinational from the register.
// Backpressure: none internally; the owner decides when to shift.
//
// Ports: clk/rst (async active-low); load+ld_dat capture a word (unused upper bits masked off);
// shift drops the current symbol; clear empties the register; dat/sym show the word and symbol 0;
// last flags one symbol remaining, full flags any symbols remaining.
module seq_unpack_buf
  import seq_unpack_pkg::*;
#(
  parameter int twidth = 3,
  parameter int wwidth = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [wwidth-1:0] ld_dat,
  input  logic              shift,
  input  logic              clear,
  output logic [wwidth-1:0] dat,
  output logic [twidth-1:0] sym,
  output logic              last,
  output logic              full
);

  localparam int NSYM = nsym_of(wwidth, twidth);
  localparam int CW   = $clog2(NSYM + 1);
  localparam logic [CW-1:0] NSYM_C = CW'(NSYM);
  // Keep only the bits that belong to whole symbols so shifted-in padding stays zero.
  localparam logic [wwidth-1:0] USED_MASK = {wwidth{1'b1}} >> (wwidth - NSYM * twidth);

  logic [CW-1:0] cnt;

  // load wins over clear and shift so a word boundary can reload in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dat <= '0;
      cnt <= '0;
    end else if (load) begin
      dat <= ld_dat & USED_MASK;
      cnt <= NSYM_C;
    end else if (clear) begin
      dat <= '0;
      cnt <= '0;
    end else if (shift) begin
      dat <= dat >> twidth;
      cnt <= cnt - 1'b1;
    end
  end

  assign sym  = dat[twidth-1:0];
  assign last = (cnt == CW'(1));
  assign full = (cnt != '0);

endmodule

// File: rtl/seq_unpack.sv
// Unpacks fixed-width symbols from FIFO words, counts symbols up to an all-ones terminator.
// Latency: first symbol valid 2 cycles after rd; 1 symbol/cycle with ack held; done 1 cycle after terminator.
// Backpressure: s/v hold while ack is low; no FIFO read while a word is still being emitted (unless prefetching).
//
// Ports: din/empty/rd - word FIFO side (din valid the cycle after rd); s/v/ack - symbol stream;
// len - symbol count of the last finished sequence (saturating); done - pulse after a terminator.
// Build option: define SEQ_UNPACK_PREFETCH_EN to add a second word register that is filled
// while the current word streams, removing the idle cycles between words.
module seq_unpack
  import seq_unpack_pkg::*;
#(
  parameter int twidth = 3,   // symbol width
  parameter int wwidth = 64,  // packed word width
  parameter int lwidth = 16   // sequence length counter width
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [wwidth-1:0] din,
  input  logic              empty,
  output logic              rd,
  output logic [twidth-1:0] s,
  output logic              v,
  input  logic              ack,
  output logic [lwidth-1:0] len,
  output logic              done
);

  localparam logic [twidth-1:0] TERM = TERM_ONES[twidth-1:0];

  state_t            state, state_nxt;
  logic              armed;
  logic [lwidth-1:0] count;
  logic              m_load, m_shift, m_clear, m_last;
  logic [wwidth-1:0] m_ld_dat;
  logic [wwidth-1:0] m_dat_unused;
  logic              m_full_unused;
  logic              xfer, is_term, finish;

  assign v       = (state == EMIT);
  assign xfer    = v && ack;
  assign is_term = (s == TERM);
  // A word ends on its last symbol or early on a terminator (the rest is discarded).
  assign finish  = xfer && (is_term || m_last);

  seq_unpack_buf #(.twidth(twidth), .wwidth(wwidth)) u_buf (
    .clk    (clk),
    .rst    (rst),
    .load   (m_load),
    .ld_dat (m_ld_dat),
    .shift  (m_shift),
    .clear  (m_clear),
    .dat    (m_dat_unused),
    .sym    (s),
    .last   (m_last),
    .full   (m_full_unused)
  );

`ifdef SEQ_UNPACK_PREFETCH_EN
  logic              din_vld;
  logic              p_load, p_clear, p_full, p_last_unused;
  logic [wwidth-1:0] p_dat;
  logic [twidth-1:0] p_sym_unused;

  seq_unpack_buf #(.twidth(twidth), .wwidth(wwidth)) u_pbuf (
    .clk    (clk),
    .rst    (rst),
    .load   (p_load),
    .ld_dat (din),
    .shift  (1'b0),
    .clear  (p_clear),
    .dat    (p_dat),
    .sym    (p_sym_unused),
    .last   (p_last_unused),
    .full   (p_full)
  );

  // din carries a fresh word the cycle after any rd.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) din_vld <= 1'b0;
    else      din_vld <= rd;
  end
`endif

  always_comb begin
    state_nxt = state;
    rd        = 1'b0;
    m_load    = 1'b0;
    m_shift   = 1'b0;
    m_clear   = 1'b0;
    m_ld_dat  = din;
`ifdef SEQ_UNPACK_PREFETCH_EN
    p_load    = 1'b0;
    p_clear   = 1'b0;
`endif
    case (state)
      // armed blocks a read in the first cycle out of reset.
      EMPTY: if (armed && !empty) begin
        rd        = 1'b1;
        state_nxt = FETCH;
      end
      FETCH: begin
        m_load    = 1'b1;
        state_nxt = EMIT;
      end
      EMIT: begin
`ifdef SEQ_UNPACK_PREFETCH_EN
        // One outstanding prefetch at most: spare register empty and no word in flight.
        rd = !p_full && !din_vld && !empty;
        if (finish) begin
          if (p_full) begin
            m_load   = 1'b1;
            m_ld_dat = p_dat;
            p_clear  = 1'b1;
          end else if (din_vld) begin
            // Prefetched word lands exactly as the current one ends: take it directly.
            m_load = 1'b1;
          end else begin
            m_clear   = 1'b1;
            // A read issued on this final cycle behaves like a normal fetch.
            state_nxt = rd ? FETCH : EMPTY;
          end
        end else begin
          m_shift = xfer;
          p_load  = din_vld;
        end
`else
        if (finish) begin
          m_clear   = 1'b1;
          state_nxt = EMPTY;
        end else begin
          m_shift = xfer;
        end
`endif
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= EMPTY;
      armed <= 1'b0;
      count <= '0;
      len   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      armed <= 1'b1;
      done  <= xfer && is_term;
      if (xfer) begin
        if (is_term) begin
          len   <= count;
          count <= '0;
        end else if (count != '1) begin
          count <= count + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_unpack.sv
module tb_seq_unpack;

  localparam int TW = 3;
  localparam int WW = 64;
  localparam int LW = 16;
  localparam int NS = 21;
`ifdef SEQ_UNPACK_PREFETCH_EN
  localparam bit PF = 1'b1;
`else
  localparam bit PF = 1'b0;
`endif

  logic          clk, rst, empty, ack;
  logic [WW-1:0] din;
  logic          rd, v, done, rd2, v2, done2;
  logic [TW-1:0] s, s2;
  logic [LW-1:0] len;
  logic [3:0]    len2;

  seq_unpack #(.twidth(TW), .wwidth(WW), .lwidth(LW)) dut (
    .clk(clk), .rst(rst), .din(din), .empty(empty), .rd(rd),
    .s(s), .v(v), .ack(ack), .len(len), .done(done)
  );

  // Same stream, 4-bit length counter to exercise saturation.
  seq_unpack #(.twidth(TW), .wwidth(WW), .lwidth(4)) dut4 (
    .clk(clk), .rst(rst), .din(din), .empty(empty), .rd(rd2),
    .s(s2), .v(v2), .ack(ack), .len(len2), .done(done2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_fail = 0;

  logic [WW-1:0] fq[$];
  int exp_q[$], got_q[$], xcyc_q[$];
  int cyc = 0, n_rd = 0, first_rd_cyc = -1, n_done = 0, done_cyc = -1;
  int rd_empty_viol = 0, stab_viol = 0, d2_diff = 0;
  logic rd_s = 1'b0, hold_p = 1'b0;
  logic [TW-1:0] hold_s = '0;

  typedef struct {
    int nwords;
    int tpos;
    int exp_len;
    int exp_len4;
    int exp_syms;
    int exp_gaps;   // idle cycles inside the sequence without prefetch
  } vec_t;
  vec_t tbl[5];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Symbols count up from start (mod 7, never the terminator); terminator at tpos,
  // filler 5 after it; top bit set to check that unused bits are ignored.
  function automatic logic [WW-1:0] mkword(input int start, input int tpos);
    logic [WW-1:0] w;
    w = '0;
    w[WW-1] = 1'b1;
    for (int i = 0; i < NS; i++) begin
      int sy;
      if (i == tpos) sy = 7;
      else if (i > tpos) sy = 5;
      else sy = (start + i) % 7;
      w[i*TW +: TW] = TW'(sy);
    end
    return w;
  endfunction

  task automatic push_word(input int start, input int tpos);
    logic [WW-1:0] w;
    w = mkword(start, tpos);
    fq.push_back(w);
    for (int i = 0; i < NS; i++) begin
      exp_q.push_back(int'(w[i*TW +: TW]));
      if (w[i*TW +: TW] == 3'd7) break;
    end
  endtask

  task automatic clr();
    got_q.delete();
    exp_q.delete();
    xcyc_q.delete();
    n_rd = 0;
    first_rd_cyc = -1;
    n_done = 0;
    done_cyc = -1;
    stab_viol = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (n_done == 0 && k < budget) begin
      step();
      k++;
    end
  endtask

  task automatic chk_stream(input string name);
    int nerr;
    nerr = 0;
    chk({name, "_nsym_model"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i] != exp_q[i]) nerr++;
    chk({name, "_sym_errs"}, nerr, 0);
  endtask

  // Word FIFO model: a read pops at the following edge, so din is valid the cycle after rd.
  initial begin
    din   = '0;
    empty = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rd_s && fq.size() > 0) din = fq.pop_front();
      rd_s  = 1'b0;
      empty = (fq.size() == 0);
    end
  end

  // Monitor on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        if (rd) begin
          n_rd++;
          rd_s = 1'b1;
          if (first_rd_cyc < 0) first_rd_cyc = cyc;
          if (empty) rd_empty_viol++;
        end
        if (hold_p && (!v || s != hold_s)) stab_viol++;
        hold_p = v && !ack;
        hold_s = s;
        if (v && ack) begin
          got_q.push_back(int'(s));
          xcyc_q.push_back(cyc);
        end
        if (done) begin
          n_done++;
          done_cyc = cyc;
        end
        if (rd2 != rd || v2 != v || s2 != s || done2 != done) d2_diff++;
      end else begin
        hold_p = 1'b0;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, bad, lat, gaps, dl;
    string nm;
    rst = 1'b0;
    ack = 1'b0;
    //           nwords tpos len len4 syms gaps
    tbl[0] = '{1,  4,   4,   4,   5,   0};
    tbl[1] = '{1,  0,   0,   0,   1,   0};
    tbl[2] = '{1,  20,  20,  15,  21,  0};
    tbl[3] = '{3,  0,   42,  15,  43,  4};
    tbl[4] = '{2,  10,  31,  15,  32,  2};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_v", int'(v), 0);
    chk("rst_rd", int'(rd), 0);
    chk("rst_s", int'(s), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_len", int'(len), 0);
    step();
    rst = 1'b1;
    repeat (2) step();

    // Single- and multi-word sequences with ack held high.
    for (int e = 0; e < 5; e++) begin
      clr();
      for (int w = 0; w < tbl[e].nwords; w++)
        push_word((e + w) % 7, (w == tbl[e].nwords - 1) ? tbl[e].tpos : 99);
      ack = 1'b1;
      wait_done(300);
      repeat (4) step();
      ack = 1'b0;
      nm = $sformatf("v%0d", e);
      chk({nm, "_nsym"}, got_q.size(), tbl[e].exp_syms);
      chk_stream(nm);
      chk({nm, "_len"}, int'(len), tbl[e].exp_len);
      chk({nm, "_len4"}, int'(len2), tbl[e].exp_len4);
      chk({nm, "_done_cnt"}, n_done, 1);
      chk({nm, "_rd_cnt"}, n_rd, tbl[e].nwords);
      lat  = (xcyc_q.size() > 0) ? xcyc_q[0] - first_rd_cyc : -1;
      chk({nm, "_first_v_lat"}, lat, 2);
      dl   = (xcyc_q.size() > 0) ? done_cyc - xcyc_q[xcyc_q.size()-1] : -1;
      chk({nm, "_done_lat"}, dl, 1);
      gaps = (xcyc_q.size() > 0) ? xcyc_q[xcyc_q.size()-1] - xcyc_q[0] + 1 - xcyc_q.size() : -1;
      chk({nm, "_gaps"}, gaps, PF ? 0 : tbl[e].exp_gaps);
    end

    // ack toggling: held symbols stay stable and each one is emitted once.
    clr();
    push_word(2, 6);
    k = 0;
    while (n_done == 0 && k < 100) begin
      ack = ~ack;
      step();
      k++;
    end
    repeat (3) step();
    ack = 1'b0;
    chk("tog_nsym", got_q.size(), 7);
    chk_stream("tog");
    chk("tog_stable_viol", stab_viol, 0);
    chk("tog_len", int'(len), 6);
    chk("tog_done_cnt", n_done, 1);

    // FIFO runs dry mid-sequence for 10 cycles; the count carries over.
    clr();
    push_word(1, 99);
    ack = 1'b1;
    k = 0;
    while (got_q.size() < NS && k < 100) begin
      step();
      k++;
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (v || rd) bad++;
    end
    step();
    chk("dry_idle_viol", bad, 0);
    chk("dry_no_done", n_done, 0);
    push_word(4, 3);
    wait_done(200);
    repeat (3) step();
    chk_stream("dry");
    chk("dry_len", int'(len), 24);
    chk("dry_len4", int'(len2), 15);
    chk("dry_rd_cnt", n_rd, 2);

    // Asynchronous reset while the third symbol of a word is presented.
    clr();
    push_word(1, 99);
    k = 0;
    while (got_q.size() < 2 && k < 100) begin
      step();
      k++;
    end
    chk("rs_pre_s", int'(s), 3);
    #1;
    rst = 1'b0;
    #1;
    chk("rs_v", int'(v), 0);
    chk("rs_s", int'(s), 0);
    chk("rs_rd", int'(rd), 0);
    chk("rs_done", int'(done), 0);
    chk("rs_len", int'(len), 0);
    chk("rs_len4", int'(len2), 0);
    clr();
    push_word(3, 2);
    repeat (2) step();
    rst = 1'b1;
    @(negedge clk);
    chk("rs_no_rd_first", int'(rd), 0);
    chk("rs_len_after", int'(len), 0);
    step();
    wait_done(100);
    repeat (3) step();
    ack = 1'b0;
    chk_stream("rs");
    chk("rs_first_sym", (got_q.size() > 0) ? got_q[0] : -1, 3);
    chk("rs_final_len", int'(len), 2);
    chk("rs_rd_cnt", n_rd, 1);
    lat = (xcyc_q.size() > 0) ? xcyc_q[0] - first_rd_cyc : -1;
    chk("rs_first_v_lat", lat, 2);

    chk("rd_while_empty", rd_empty_viol, 0);
    chk("dut4_ctrl_diff", d2_diff, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
